// File: rtl/packed_switch_stage_pipe.sv
// packed_switch_stage_pipe: one stage of 2x2 lane switches with a config bank and skid-buffered output
module packed_switch_stage_pipe #(
    parameter int DATA_WIDTH = 512,
    parameter int PORT_SIZE = 32,
    parameter int STRIDE = 1,
    parameter int CFG_DEPTH = 4,
    localparam int SWITCH_SIZE = PORT_SIZE / 2,
    localparam int CFG_AW = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [CFG_AW-1:0]                cfg_addr,
    input  logic [SWITCH_SIZE-1:0]           cfg_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CFG_AW-1:0]                in_cfg_sel,
    input  logic [DATA_WIDTH*PORT_SIZE-1:0]  in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PORT_SIZE-1:0]  out_data,
    output logic                             cfg_err
);
    localparam int LW = DATA_WIDTH * PORT_SIZE;

    logic [SWITCH_SIZE-1:0] bank_q [CFG_DEPTH];
    logic [SWITCH_SIZE-1:0] bank_d [CFG_DEPTH];
    logic                   out_valid_q, out_valid_d;
    logic [LW-1:0]          out_data_q, out_data_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [LW-1:0]          skid_data_q, skid_data_d;
    logic                   in_ready_q, in_ready_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [SWITCH_SIZE-1:0] sw;
    logic [LW-1:0]          perm;
    logic                   sel_ok, addr_ok, accept, free;

    // low lane of switch k: pairs are grouped in blocks of 2*STRIDE lanes
    function automatic int lo_lane(input int k);
        return (k / STRIDE) * 2 * STRIDE + (k % STRIDE);
    endfunction

    assign sel_ok    = 32'(in_cfg_sel) < CFG_DEPTH;
    assign addr_ok   = 32'(cfg_addr) < CFG_DEPTH;
    assign accept    = in_valid && in_ready_q;
    assign free      = !out_valid_q || out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

    // apply the selected switch settings; out-of-range selection falls back to pass
    always_comb begin
        sw = sel_ok ? bank_q[in_cfg_sel] : '0;
        perm = in_data;
        for (int k = 0; k < SWITCH_SIZE; k++) begin
            perm[lo_lane(k)*DATA_WIDTH +: DATA_WIDTH] = sw[k] ? in_data[(lo_lane(k)+STRIDE)*DATA_WIDTH +: DATA_WIDTH]
                                                              : in_data[lo_lane(k)*DATA_WIDTH +: DATA_WIDTH];
            perm[(lo_lane(k)+STRIDE)*DATA_WIDTH +: DATA_WIDTH] = sw[k] ? in_data[lo_lane(k)*DATA_WIDTH +: DATA_WIDTH]
                                                                       : in_data[(lo_lane(k)+STRIDE)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // output register refills from skid first, else from the new beat; a held output diverts the beat to skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (free) begin
            out_valid_d  = skid_valid_q || accept;
            out_data_d   = skid_valid_q ? skid_data_q : (accept ? perm : out_data_q);
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm;
        end
        in_ready_d = !skid_valid_d;
        cfg_err_d  = cfg_err_q || (cfg_we && !addr_ok) || (accept && !sel_ok);
        bank_d     = bank_q;
        if (cfg_we && addr_ok) bank_d[cfg_addr] = cfg_data;
    end

    // state update; reset clears the pipe and returns every bank entry to pass
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            cfg_err_q    <= 1'b0;
            bank_q       <= '{default: '0};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            cfg_err_q    <= cfg_err_d;
            bank_q       <= bank_d;
        end
    end
endmodule

// File: doc/packed_switch_stage_pipe.md
PACKED_SWITCH_STAGE_PIPE -- requirements
Module: packed_switch_stage_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 512, bit width of one port lane.
REQ-002 Parameter PORT_SIZE, default 32, number of lanes; even, >= 2.
REQ-003 Parameter STRIDE, default 1, pairing distance; power of two; PORT_SIZE is a multiple of 2*STRIDE.
REQ-004 Parameter CFG_DEPTH, default 4, number of stored switch configurations; >= 1.
REQ-005 Derived SWITCH_SIZE = PORT_SIZE/2; CFG_AW = max(1, clog2(CFG_DEPTH)).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 cfg_we  input  1  configuration-bank write strobe.
REQ-009 cfg_addr  input  CFG_AW  configuration-bank write address.
REQ-010 cfg_data  input  SWITCH_SIZE  switch settings written; bit k controls switch k.
REQ-011 in_valid  input  1  input beat valid.
REQ-012 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-013 in_cfg_sel  input  CFG_AW  configuration entry applied to this beat.
REQ-014 in_data  input  DATA_WIDTH*PORT_SIZE  lane p at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-015 out_valid  output  1  output beat valid.
REQ-016 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-017 out_data  output  DATA_WIDTH*PORT_SIZE  permuted lanes, same packing as in_data.
REQ-018 cfg_err  output  1  sticky flag, out-of-range address used.

Function
REQ-019 Pairing: lane j with (j mod 2*STRIDE) < STRIDE is the low lane of a pair whose high lane is j+STRIDE; switch k serves the k-th pair in ascending low-lane order.
REQ-020 Switch bit 0 = pass (out[lo]=in[lo], out[hi]=in[hi]); bit 1 = cross (out[lo]=in[hi], out[hi]=in[lo]).
REQ-021 STRIDE=1 pairs adjacent lanes (2k, 2k+1) as switch k.
REQ-022 Config bank: CFG_DEPTH entries of SWITCH_SIZE bits, written when cfg_we, value visible from the next cycle.
REQ-023 Accepted beat is permuted with bank[in_cfg_sel] as held at the acceptance edge; simultaneous write to the same entry does not affect that beat.
REQ-024 in_cfg_sel or cfg_addr >= CFG_DEPTH: beat uses all-zero (pass) setting, write ignored, cfg_err set until reset.
REQ-025 Datapath: output register plus one skid register; full throughput with out_ready held high; latency 1 cycle acceptance-to-out_valid.
REQ-026 in_ready is a register output: in_ready = not skid_valid; no combinational path from out_ready to in_ready.
REQ-027 Beat accepted while output register empty or draining: loads output register; accepted while output register held (out_valid && !out_ready): loads skid register.
REQ-028 Output drain with skid full: skid moves to output register, in_ready rises next cycle.
REQ-029 out_data and out_valid stable while out_valid && !out_ready.
REQ-030 Beats leave in acceptance order; none dropped, none duplicated.
REQ-031 Simultaneous accept and drain with skid empty: new beat replaces output register in same edge, out_valid stays 1.

Reset
REQ-032 rst at rising edge: out_valid=0, skid_valid=0, in_ready=1 next cycle, cfg_err=0, all bank entries=0 (pass).
REQ-033 rst mid-transfer discards output and skid contents; in_valid/cfg_we ignored in the reset cycle.
REQ-034 out_data after reset is 0.

Verification
REQ-035 PORT_SIZE=4, STRIDE=1, bank[0]=0b01, in lanes {A,B,C,D}, out_ready=1 -> next cycle out_valid=1, lanes {B,A,C,D}.
REQ-036 PORT_SIZE=8, STRIDE=2, bank[1]=0b1111, lanes 0..7 -> out lanes {2,3,0,1,6,7,4,5}.
REQ-037 out_ready=0, three beats offered back-to-back -> first two accepted, in_ready=0 from cycle 2; release out_ready -> beats out in order, in_ready=1 one cycle after first drain.
REQ-038 cfg_we to entry 2 and beat with in_cfg_sel=2 same cycle -> beat uses old value; next beat uses new value.
REQ-039 CFG_DEPTH=3, in_cfg_sel=3 -> pass-through output, cfg_err=1, held until rst.
REQ-040 rst asserted with skid full -> next cycle out_valid=0, in_ready=1, bank all pass.
